// File: rtl/camo_oracle_driver.sv
`timescale 1ns/1ps
// camo_oracle_driver: initiator that applies one input pattern to the camouflaged netlist,
// steps it once and returns Q1..Q3. Define CAMO_ORACLE_SIG_EN to enable the 8-bit MISR on sig.
module camo_oracle_driver #(
    parameter int SETTLE_CYC = 2,
    parameter int NUM_IN     = 4,
    parameter int NUM_OUT    = 3,
    parameter int CNT_W      = 16
) (
    input  logic               CLK,
    input  logic               NRST,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [NUM_IN-1:0]  req_pat,
    input  logic               req_rst,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [NUM_OUT-1:0] rsp_q,
    output logic [CNT_W-1:0]   qcount,
    output logic [NUM_IN-1:0]  dut_in,
    output logic               dut_nrst,
    output logic               dut_clk_en,
    input  logic [NUM_OUT-1:0] dut_q,
    output logic [7:0]         sig
);

    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
        $error("camo_oracle_driver: SETTLE_CYC must be within 1..15");
    end

    typedef enum logic [2:0] {IDLE, DRST, APPLY, STEP, HOLD, RESP} state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);
    localparam logic [3:0] DRST_LD   = 4'd1;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [NUM_IN-1:0]  pat_q, pat_d;
    logic               req_ready_d, rsp_valid_d, dut_nrst_d, dut_clk_en_d;
    logic [NUM_OUT-1:0] rsp_q_d;
    logic [CNT_W-1:0]   qcount_d;
    logic [NUM_IN-1:0]  dut_in_d;

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pat_d        = pat_q;
        req_ready_d  = req_ready;
        rsp_valid_d  = rsp_valid;
        rsp_q_d      = rsp_q;
        qcount_d     = qcount;
        dut_in_d     = dut_in;
        dut_nrst_d   = dut_nrst;
        dut_clk_en_d = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                dut_nrst_d  = 1'b1;
                if (req_valid && req_ready) begin
                    pat_d       = req_pat;
                    req_ready_d = 1'b0;
                    if (req_rst) begin
                        state_d    = DRST;
                        cnt_d      = DRST_LD;
                        dut_nrst_d = 1'b0;
                        dut_in_d   = '0;
                    end else begin
                        state_d  = APPLY;
                        cnt_d    = SETTLE_LD;
                        dut_in_d = req_pat;
                    end
                end
            end
            DRST: begin
                if (cnt_q == 4'd0) begin
                    state_d    = APPLY;
                    cnt_d      = SETTLE_LD;
                    dut_nrst_d = 1'b1;
                    dut_in_d   = pat_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            APPLY: begin
                if (cnt_q == 4'd0) begin
                    state_d      = STEP;
                    dut_clk_en_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STEP: begin
                state_d = HOLD;
                cnt_d   = SETTLE_LD;
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_q_d     = dut_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    qcount_d    = (qcount == '1) ? qcount : qcount + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every register samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pat_q      <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_q      <= '0;
            qcount     <= '0;
            dut_in     <= '0;
            dut_nrst   <= 1'b0;
            dut_clk_en <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pat_q      <= pat_d;
            req_ready  <= req_ready_d;
            rsp_valid  <= rsp_valid_d;
            rsp_q      <= rsp_q_d;
            qcount     <= qcount_d;
            dut_in     <= dut_in_d;
            dut_nrst   <= dut_nrst_d;
            dut_clk_en <= dut_clk_en_d;
        end
    end

`ifdef CAMO_ORACLE_SIG_EN
    // Galois MISR for x^8+x^4+x^3+x^2+1; the response is folded in after the shift.
    logic [7:0] sig_q;
    logic [7:0] sig_shift;

    assign sig_shift = {sig_q[6:0], 1'b0} ^ (sig_q[7] ? 8'h1D : 8'h00);

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            sig_q <= '0;
        end else if (rsp_valid && rsp_ready) begin
            sig_q <= sig_shift ^ 8'(rsp_q);
        end
    end

    assign sig = sig_q;
`else
    assign sig = 8'h00;
`endif

endmodule

// File: tb/tb_camo_oracle_driver.sv
`timescale 1ns/1ps
// tb_camo_oracle_driver: cycle-offset transaction model of the driver plus a behavioural
// stand-in for the camouflaged netlist; a negedge monitor compares every output each cycle.
module tb_camo_oracle_driver;

    localparam int S    = 2;
    localparam int CW   = 3;
    localparam int QMAX = (1 << CW) - 1;

    logic          CLK       = 1'b0;
    logic          NRST      = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_pat   = 4'b0000;
    logic          req_rst   = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [2:0]    rsp_q;
    logic [CW-1:0] qcount;
    logic [3:0]    dut_in;
    logic          dut_nrst;
    logic          dut_clk_en;
    logic [2:0]    dut_q;
    logic [7:0]    sig;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    always #5 CLK = ~CLK;

    camo_oracle_driver #(
        .SETTLE_CYC(S), .NUM_IN(4), .NUM_OUT(3), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .NRST(NRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_pat(req_pat), .req_rst(req_rst),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q), .qcount(qcount),
        .dut_in(dut_in), .dut_nrst(dut_nrst), .dut_clk_en(dut_clk_en), .dut_q(dut_q),
        .sig(sig)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Stand-in netlist: Q1'=a^b^Q3, Q2'=Q1|(c&d), Q3'=Q2^d; state bits {Q3,Q2,Q1}, p={a,b,c,d}.
    function automatic logic [2:0] nl_next(input logic [2:0] st, input logic [3:0] p);
        return {st[1] ^ p[0], st[0] | (p[1] & p[0]), p[3] ^ p[2] ^ st[2]};
    endfunction

`ifdef CAMO_ORACLE_SIG_EN
    function automatic logic [7:0] misr(input logic [7:0] s, input logic [2:0] d);
        logic [8:0] w;
        w = {s, 1'b0};
        if (w[8]) w = w ^ 9'h11D;
        return w[7:0] ^ {5'b00000, d};
    endfunction
`endif

    logic [2:0] plant_st = 3'b000;
    always @(posedge CLK or negedge dut_nrst) begin
        if (!dut_nrst) plant_st <= 3'b000;
        else if (dut_clk_en) plant_st <= nl_next(plant_st, dut_in);
    end
    assign dut_q = plant_st;

    // Driver model: expectations derived from edge offsets since the accepting edge.
    bit         m_busy  = 1'b0;
    int         m_t     = 0;
    logic       m_rst   = 1'b0;
    logic [3:0] m_pat   = 4'b0000;
    logic [2:0] m_exp   = 3'b000;
    logic [2:0] m_st    = 3'b000;
    logic       m_ready = 1'b0;
    logic       m_valid = 1'b0;
    logic       m_nrst  = 1'b0;
    logic       m_clken = 1'b0;
    logic [2:0] m_rspq  = 3'b000;
    logic [3:0] m_din   = 4'b0000;
    int         m_qc    = 0;
    logic [7:0] m_sig   = 8'h00;

    always @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            m_busy = 1'b0; m_ready = 1'b0; m_valid = 1'b0; m_nrst = 1'b0; m_clken = 1'b0;
            m_rspq = 3'b000; m_din = 4'b0000; m_qc = 0; m_sig = 8'h00; m_st = 3'b000;
        end else begin
            int d;
            if (m_valid && rsp_ready) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
                m_busy  = 1'b0;
                m_qc    = (m_qc == QMAX) ? QMAX : m_qc + 1;
`ifdef CAMO_ORACLE_SIG_EN
                m_sig   = misr(m_sig, m_rspq);
`endif
            end else if (!m_busy && m_ready && req_valid) begin
                m_busy  = 1'b1;
                m_t     = 0;
                m_pat   = req_pat;
                m_rst   = req_rst;
                m_ready = 1'b0;
                m_exp   = nl_next(req_rst ? 3'b000 : m_st, req_pat);
                m_st    = m_exp;
            end else if (!m_busy) begin
                m_ready = 1'b1;
                m_nrst  = 1'b1;
            end else if (!m_valid) begin
                m_t++;
            end
            if (m_busy && !m_valid) begin
                d       = m_rst ? 2 : 0;
                m_nrst  = !(m_rst && m_t < 2);
                m_din   = (m_rst && m_t < 2) ? 4'b0000 : m_pat;
                m_clken = (m_t == d + S);
                if (m_t == d + 2 * S + 1) begin
                    m_valid = 1'b1;
                    m_rspq  = m_exp;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (mon_en) begin
            check("mon_req_ready",  32'(req_ready),  32'(m_ready));
            check("mon_rsp_valid",  32'(rsp_valid),  32'(m_valid));
            check("mon_rsp_q",      32'(rsp_q),      32'(m_rspq));
            check("mon_qcount",     32'(qcount),     32'(m_qc));
            check("mon_dut_in",     32'(dut_in),     32'(m_din));
            check("mon_dut_nrst",   32'(dut_nrst),   32'(m_nrst));
            check("mon_dut_clk_en", 32'(dut_clk_en), 32'(m_clken));
            check("mon_sig",        32'(sig),        32'(m_sig));
        end
    end

    task automatic query(input logic [3:0] pat, input logic rst, input int bp, input int exp_qc_hold,
                         output logic [2:0] q, output int lat, output int nrst_low, output int pulses);
        int waitc;
        waitc     = 0;
        req_pat   = pat;
        req_rst   = rst;
        req_valid = 1'b1;
        rsp_ready = (bp == 0);
        while (req_ready !== 1'b1 && waitc < 50) begin
            @(negedge CLK);
            waitc++;
        end
        check("accept_wait", 32'(req_ready), 32'd1);
        @(negedge CLK);
        req_valid = 1'b0;
        lat = 0; nrst_low = 0; pulses = 0;
        while (rsp_valid !== 1'b1 && lat < 50) begin
            if (dut_nrst === 1'b0) nrst_low++;
            if (dut_clk_en === 1'b1) pulses++;
            @(negedge CLK);
            lat++;
        end
        q = rsp_q;
        if (bp > 0) begin
            repeat (bp) @(negedge CLK);
            check("bp_qcount_hold", 32'(qcount), 32'(exp_qc_hold));
            check("bp_req_ready_low", 32'(req_ready), 32'd0);
            rsp_ready = 1'b1;
        end
        @(negedge CLK);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] q;
        int lat, nl, pu, tot_nl, tot_pu;
        logic [3:0] seq_pat [4];
        logic [2:0] seq_exp [4];
        seq_pat = '{4'b0000, 4'b1111, 4'b1111, 4'b1111};
        seq_exp = '{3'b000, 3'b110, 3'b011, 3'b010};

        // Reset: three cycles low, then one edge to come up.
        #2 NRST = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_dut_nrst",  32'(dut_nrst),  32'd0);
        check("rst_qcount",    32'(qcount),    32'd0);
        check("rst_dut_in",    32'(dut_in),    32'd0);
        check("rst_sig",       32'(sig),       32'd0);
        #2 NRST = 1'b1;
        @(negedge CLK);
        check("rel_req_ready", 32'(req_ready), 32'd1);
        check("rel_dut_nrst",  32'(dut_nrst),  32'd1);

        // Single query with DUT reset.
        query(4'b1011, 1'b1, 0, 0, q, lat, nl, pu);
        check("single_rsp",       32'(q),      32'b111);
        check("single_latency",   32'(lat),    32'd7);
        check("single_nrst_low",  32'(nl),     32'd2);
        check("single_pulses",    32'(pu),     32'd1);
        check("single_dut_in",    32'(dut_in), 32'b1011);
        check("single_qcount",    32'(qcount), 32'd1);

        // Backpressure, no DUT reset.
        query(4'b0110, 1'b0, 10, 1, q, lat, nl, pu);
        check("bp_rsp",      32'(q),      32'b110);
        check("bp_latency",  32'(lat),    32'd5);
        check("bp_nrst_low", 32'(nl),     32'd0);
        check("bp_qcount",   32'(qcount), 32'd2);

        // Stateful sequence.
        tot_nl = 0; tot_pu = 0;
        for (int i = 0; i < 4; i++) begin
            query(seq_pat[i], (i == 0), 0, 0, q, lat, nl, pu);
            check($sformatf("seq_rsp%0d", i), 32'(q), 32'(seq_exp[i]));
            tot_nl += nl;
            tot_pu += pu;
        end
        check("seq_pulses",   32'(tot_pu), 32'd4);
        check("seq_nrst_low", 32'(tot_nl), 32'd2);
        check("seq_qcount",   32'(qcount), 32'd6);

        // Reset during HOLD.
        req_pat = 4'b0101; req_rst = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge CLK);
        req_valid = 1'b0;
        repeat (3) @(negedge CLK);
        #2 NRST = 1'b0;
        @(negedge CLK);
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_dut_nrst",  32'(dut_nrst),  32'd0);
        check("mid_qcount",    32'(qcount),    32'd0);
        repeat (2) @(negedge CLK);
        check("mid_no_rsp",    32'(rsp_valid), 32'd0);
        #2 NRST = 1'b1;
        @(negedge CLK);
        check("mid_rel_ready", 32'(req_ready), 32'd1);

        // Post-reset queries producing 3'b101 then 3'b010 for the signature.
        query(4'b1001, 1'b0, 0, 0, q, lat, nl, pu);
        check("post_rsp", 32'(q), 32'b101);
`ifdef CAMO_ORACLE_SIG_EN
        check("sig_after_101", 32'(sig), 32'h05);
`else
        check("sig_after_101", 32'(sig), 32'h00);
`endif
        query(4'b1000, 1'b0, 0, 0, q, lat, nl, pu);
        check("post_rsp2",   32'(q),      32'b010);
        check("post_qcount", 32'(qcount), 32'd2);
`ifdef CAMO_ORACLE_SIG_EN
        check("sig_after_010", 32'(sig), 32'h08);
`else
        check("sig_after_010", 32'(sig), 32'h00);
`endif

        // Saturation of the query counter.
        for (int i = 0; i < 7; i++) query(4'b0000, 1'b0, 0, 0, q, lat, nl, pu);
        check("sat_qcount", 32'(qcount), 32'(QMAX));

        repeat (3) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/camo_oracle_driver.md
Name: camo_oracle_driver

Overview:
- Query-side driver for the camouflaged 4-input/3-output sequential netlist. It acts as the initiator; the camouflaged netlist is the responder.
- Accepts input patterns over a valid/ready request channel. For each pattern it optionally resets the DUT, applies the pattern, advances the DUT exactly one clock, then captures Q1..Q3.
- Returns captured responses over a valid/ready response channel.
- Sits between the key-recovery/test controller and the camouflaged netlist on the evaluation board or in the bench.

Parameters:
- SETTLE_CYC, 2, settle cycles before and after the DUT step (legal range 1..15; 0 is an elaboration error).
- NUM_IN, 4, DUT input width (a,b,c,d).
- NUM_OUT, 3, DUT output width (Q1,Q2,Q3).
- CNT_W, 16, query counter width.

Ports:
- CLK  input  1  system clock, rising edge.
- NRST  input  1  reset, asynchronous assert, active-low.
- req_valid  input  1  request valid.
- req_ready  output  1  request ready.
- req_pat  input  NUM_IN  pattern; bit3..0 = a,b,c,d.
- req_rst  input  1  reset the DUT before applying this pattern.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response ready.
- rsp_q  output  NUM_OUT  captured outputs; bit2..0 = Q3,Q2,Q1.
- qcount  output  CNT_W  completed query count.
- dut_in  output  NUM_IN  drives DUT a..d.
- dut_nrst  output  1  DUT reset, active-low.
- dut_clk_en  output  1  DUT clock-gate enable; high for exactly one cycle per step.
- dut_q  input  NUM_OUT  DUT outputs.
- sig  output  8  response signature (see Optional Feature).

Behaviour:
- All state is in flops on CLK, with asynchronous clear on NRST low.
- Reset values: req_ready=0, rsp_valid=0, rsp_q=0, qcount=0, dut_in=0, dut_nrst=0, dut_clk_en=0, sig=0, FSM=IDLE.
- Outputs are registered; there is no combinational path from inputs to outputs.
- FSM states: IDLE, DRST, APPLY, STEP, HOLD, RESP.
- IDLE:
  - req_ready=1; dut_nrst=1 from the first edge after reset release.
  - On req_valid & req_ready: latch req_pat and req_rst; set req_ready=0.
  - Go to DRST if req_rst=1, else APPLY.
- DRST:
  - 2 cycles; dut_nrst=0, dut_in=0, dut_clk_en=0.
  - Then go to APPLY with dut_nrst=1.
- APPLY:
  - dut_in=latched pattern; hold SETTLE_CYC cycles, counted by an internal counter loaded with SETTLE_CYC-1.
  - Then go to STEP.
- STEP:
  - dut_clk_en=1 for exactly 1 cycle.
  - Then go to HOLD.
- HOLD:
  - SETTLE_CYC cycles.
  - On the exit edge, sample dut_q into rsp_q, set rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid and rsp_q stay stable until rsp_ready is high.
  - On handshake: rsp_valid=0; qcount increments, saturating at all-ones; go to IDLE.
- dut_in keeps the last pattern after a query until the next APPLY or DRST. It does not return to 0 in IDLE.
- Latency from the accept edge to rsp_valid high: 2*SETTLE_CYC+1 cycles without DUT reset, 2*SETTLE_CYC+3 with it. With defaults: 5 and 7.
- Throughput: at most one query in flight. req_valid while busy is not accepted, because req_ready=0.
- Back-to-back: req_ready rises on the edge that completes the response handshake. A new request is accepted no earlier than the following edge.
- rsp_ready held high before rsp_valid rises: the handshake completes on the first cycle rsp_valid is high.
- NRST mid-query:
  - Immediate return to reset values; the query is discarded with no response.
  - dut_nrst is driven low, so the DUT is reset as well.
- qcount saturation: at 2^CNT_W-1, further handshakes leave it unchanged.

Optional Feature:
- Macro: CAMO_ORACLE_SIG_EN.
- Defined:
  - sig is an 8-bit MISR, polynomial x^8+x^4+x^3+x^2+1, seed 0.
  - It updates on every response handshake with {5'b0, rsp_q} XORed into the shift.
  - It is cleared only by NRST.
- Undefined: sig is tied to 0 and the MISR logic is absent.

Test Plan:
- Reset check: NRST low 3 cycles then high -> all outputs at reset values during reset. req_ready=1 and dut_nrst=1 one edge after release.
- Single query: req_pat=4'b1011, req_rst=1, rsp_ready=1, SETTLE_CYC=2 -> dut_nrst low exactly 2 cycles. dut_in=4'b1011, dut_clk_en pulses once. rsp_valid rises 7 cycles after accept; rsp_q equals the bench model of the DUT; qcount=1.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_q stable, req_ready=0 throughout, qcount unchanged until handshake.
- Stateful sequence: req_rst=1 with 4'b0000, then req_rst=0 with 4'b1111 three times -> exactly 4 dut_clk_en pulses, dut_nrst low only in the first query, and 4 responses in order.
- Reset mid-query: assert NRST during HOLD -> no response, dut_nrst=0, qcount=0. A query after release completes normally.
- CAMO_ORACLE_SIG_EN: responses 3'b101 then 3'b010 -> sig matches the reference MISR value. With the macro undefined, sig=0.
